mov_wb_buffer: RTL and testbench

MOV_WB_BUFFER -- requirements
Module: mov_wb_buffer

---
 rtl/mov_wb_pkg.sv | 19 +
 rtl/mov_wb_fwd_match.sv | 36 +++
 rtl/port_define.sv | 6 +
 rtl/mov_wb_buffer.sv | 100 ++++++++++
 tb/tb_mov_wb_buffer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mov_wb_pkg.sv
// Shared types for the MOV write-back buffer: pending-entry struct and default sizing.
`ifndef PORT_DEFINE_SV
`include "port_define.sv"
`endif

package mov_wb_pkg;

    localparam int MOV_WB_DEPTH = 2;
    localparam int MOV_WB_AW    = 5;

    typedef logic [`RegBus] reg_data_t;

    // addr field is sized by MOV_WB_AW; instances keep AW equal to it.
    typedef struct packed {
        logic [MOV_WB_AW-1:0] addr;
        reg_data_t            data;
    } wb_entry_t;

endpackage

// File: rtl/mov_wb_fwd_match.sv
// Forwarding lookup over pending write-back entries; pure combinational, youngest match wins.
// No flow control: reads only registered buffer state, so an entry being enqueued is invisible.
module mov_wb_fwd_match
    import mov_wb_pkg::*;
#(
    parameter int DEPTH = MOV_WB_DEPTH,
    parameter int AW    = MOV_WB_AW
) (
    input  wb_entry_t                entries_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head_i,
    input  logic [$clog2(DEPTH):0]   count_i,
    input  logic [AW-1:0]            rd_addr_i,
    output logic                     hit_o,
    output reg_data_t                data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if ((CNT_W'(i) < count_i) && (entries_i[idx].addr == rd_addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/port_define.sv
// Shared register-file port width macros used across the core.
`ifndef PORT_DEFINE_SV
`define PORT_DEFINE_SV
`define RegWidth 32
`define RegBus   31:0
`endif

// File: rtl/mov_wb_buffer.sv
// In-order MOV write-back FIFO, 1-cycle min latency; in_ready = not full (independent of rf_ready).
// Decode-stage forwarding is compiled in only when MOV_WB_FWD_EN is defined; otherwise fwd_* tie to 0.
module mov_wb_buffer
    import mov_wb_pkg::*;
#(
    parameter int DEPTH = MOV_WB_DEPTH,
    parameter int AW    = MOV_WB_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  reg_data_t              in_data,
    input  logic [AW-1:0]          in_addr,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_waddr,
    output reg_data_t              rf_wdata,
    input  logic                   rf_ready,
    input  logic [AW-1:0]          rd_addr,
    output logic                   fwd_hit,
    output reg_data_t              fwd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign rf_we    = (count_q != '0);
    assign push     = in_valid && in_ready;
    assign pop      = rf_we && rf_ready;
    assign count    = count_q;

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{addr: in_addr, data: in_data};
        end
    end

    // Storage is never reset, so mask the head view while empty.
    assign rf_waddr = rf_we ? mem_q[rd_ptr_q].addr : '0;
    assign rf_wdata = rf_we ? mem_q[rd_ptr_q].data : '0;

`ifdef MOV_WB_FWD_EN
    mov_wb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fwd_match (
        .entries_i (mem_q),
        .head_i    (rd_ptr_q),
        .count_i   (count_q),
        .rd_addr_i (rd_addr),
        .hit_o     (fwd_hit),
        .data_o    (fwd_data)
    );
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_mov_wb_buffer.sv
// Directed bench for mov_wb_buffer: queue-based reference model checked every cycle plus literal expectations.
module tb_mov_wb_buffer;
    import mov_wb_pkg::*;

    localparam int DEPTH = 2;
    localparam int AW    = 5;
`ifdef MOV_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic [AW-1:0] in_addr;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [31:0]   rf_wdata;
    logic          rf_ready;
    logic [AW-1:0] rd_addr;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [1:0]    count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    wb_entry_t     mq[$];
    logic [AW-1:0] wr_log[$];
    logic          m_push, m_pop, exp_hit;
    logic [31:0]   exp_fwd;

    mov_wb_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_addr  (in_addr),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rf_ready (rf_ready),
        .rd_addr  (rd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [AW-1:0] a, input logic [31:0] d, input logic rr);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        rf_ready = rr;
    endtask

    // Reference: bounded in-order queue; forwarding = youngest queued entry with matching addr.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            m_pop  = (mq.size() != 0) && rf_ready;
            m_push = in_valid && (mq.size() < DEPTH);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back('{addr: in_addr, data: in_data});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_hit = 1'b0;
            exp_fwd = '0;
            if (FWD) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].addr == rd_addr) begin
                        exp_hit = 1'b1;
                        exp_fwd = mq[i].data;
                    end
                end
            end
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            chk("m_rf_we", 32'(rf_we), 32'(mq.size() != 0));
            chk("m_rf_waddr", 32'(rf_waddr), (mq.size() != 0) ? 32'(mq[0].addr) : 32'h0);
            chk("m_rf_wdata", rf_wdata, (mq.size() != 0) ? mq[0].data : 32'h0);
            chk("m_fwd_hit", 32'(fwd_hit), 32'(exp_hit));
            chk("m_fwd_data", fwd_data, exp_fwd);
            if (rf_we && rf_ready) wr_log.push_back(rf_waddr);
        end
    end

    initial begin
        logic [31:0] got;
        rst = 1'b1;
        rd_addr = '0;
        set_in(1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        rst = 1'b0;

        // Single entry appears one cycle after acceptance.
        set_in(1'b1, 5'd3, 32'h1234_5678, 1'b0);
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b0);
        chk("lat_rf_we", 32'(rf_we), 32'd1);
        chk("lat_rf_waddr", 32'(rf_waddr), 32'd3);
        chk("lat_rf_wdata", rf_wdata, 32'h1234_5678);
        chk("lat_count", 32'(count), 32'd1);
        rf_ready = 1'b1;
        tick();
        rf_ready = 1'b0;
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_wdata", rf_wdata, 32'h0);

        // Fill, drop on full, then drain in order.
        set_in(1'b1, 5'd1, 32'h11, 1'b0);
        tick();
        set_in(1'b1, 5'd2, 32'h22, 1'b0);
        tick();
        chk("full_count", 32'(count), 32'd2);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        set_in(1'b1, 5'd7, 32'h77, 1'b0);
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b0);
        chk("drop_count", 32'(count), 32'd2);
        chk("drop_head", 32'(rf_waddr), 32'd1);
        wr_log.delete();
        rf_ready = 1'b1;
        tick();
        tick();
        rf_ready = 1'b0;
        chk("order_n", 32'(wr_log.size()), 32'd2);
        got = (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hFFFF_FFFF;
        chk("order_0", got, 32'd1);
        got = (wr_log.size() > 1) ? 32'(wr_log[1]) : 32'hFFFF_FFFF;
        chk("order_1", got, 32'd2);
        chk("empty_count", 32'(count), 32'd0);

        // Steady-state push+pop across pointer wrap.
        set_in(1'b1, 5'd10, 32'h100, 1'b0);
        tick();
        wr_log.delete();
        for (int k = 0; k < 10; k++) begin
            set_in(1'b1, 5'(11 + k), 32'(32'h200 + k), 1'b1);
            tick();
            chk("wrap_count", 32'(count), 32'd1);
        end
        set_in(1'b0, 5'd0, 32'h0, 1'b1);
        tick();
        rf_ready = 1'b0;
        chk("wrap_n", 32'(wr_log.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            got = (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hFFFF_FFFF;
            chk("wrap_order", got, 32'(10 + i));
        end

        // Forwarding: youngest of two same-address entries.
        set_in(1'b1, 5'd5, 32'hA, 1'b0);
        tick();
        set_in(1'b1, 5'd5, 32'hB, 1'b0);
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b0);
        rd_addr = 5'd5;
        #1;
        chk("fwd5_hit", 32'(fwd_hit), FWD ? 32'd1 : 32'd0);
        chk("fwd5_data", fwd_data, FWD ? 32'hB : 32'h0);
        rd_addr = 5'd6;
        #1;
        chk("fwd6_hit", 32'(fwd_hit), 32'd0);
        chk("fwd6_data", fwd_data, 32'h0);
        chk("fwd_wb_head", rf_wdata, 32'hA);
        rf_ready = 1'b1;
        tick();
        rf_ready = 1'b0;
        // Entry being enqueued this cycle must not forward.
        set_in(1'b1, 5'd9, 32'h99, 1'b0);
        rd_addr = 5'd9;
        #1;
        chk("fwd_enq_hit", 32'(fwd_hit), 32'd0);
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b0);
        chk("fwd9_hit", 32'(fwd_hit), FWD ? 32'd1 : 32'd0);
        chk("fwd9_data", fwd_data, FWD ? 32'h99 : 32'h0);

        // Reset wins over a concurrent enqueue while full.
        chk("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b1;
        set_in(1'b1, 5'd4, 32'h44, 1'b1);
        rd_addr = 5'd4;
        tick();
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 1'b0);
        rd_addr = 5'd5;
        #1;
        chk("rst2_count", 32'(count), 32'd0);
        chk("rst2_rf_we", 32'(rf_we), 32'd0);
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        chk("rst2_fwd_hit", 32'(fwd_hit), 32'd0);
        chk("rst2_fwd_data", fwd_data, 32'h0);

        // Mixed traffic on a small address set, checked by the model each cycle.
        for (int k = 0; k < 60; k++) begin
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
            rd_addr = 5'($urandom_range(0, 3));
            tick();
        end
        set_in(1'b0, 5'd0, 32'h0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
